// File: rtl/char_console_ctrl.sv
// char_console_ctrl: text-console sequencer owning the processor port of the
// character frame buffer. Accepts character/colour bytes and turns them into
// frame-buffer writes at a hardware cursor, with CR, LF, line wrap,
// clear-screen (FF) and a hardware scroll that copies the buffer up one row.
//
// Ports:
//   axi4clk, reset_axi           clock, synchronous active-high reset
//   char_valid/char_ready        byte handshake, transfer when both high
//   char_data[7:0]               character or control code
//   char_color[8:0]              {R[2:0],G[2:0],B[2:0]} attribute
//   fb_addr/fb_din/fb_we         frame-buffer write/read port
//   fb_dout[15:0]                read data, valid the cycle after fb_addr
//   cursor_col/cursor_row        current cursor position
//   busy                         high whenever not idle
module char_console_ctrl #(
  parameter int unsigned COLS       = 100,
  parameter int unsigned ROWS       = 75,
  parameter int unsigned ADDR_WIDTH = 13
) (
  input  logic                      axi4clk,
  input  logic                      reset_axi,
  input  logic                      char_valid,
  output logic                      char_ready,
  input  logic [7:0]                char_data,
  input  logic [8:0]                char_color,
  output logic [ADDR_WIDTH-1:0]     fb_addr,
  output logic [15:0]               fb_din,
  output logic                      fb_we,
  input  logic [15:0]               fb_dout,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic                      busy
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned AW = ADDR_WIDTH;

  localparam logic [AW-1:0] COLS_A        = AW'(COLS);
  localparam logic [AW-1:0] SCROLL_LAST   = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] LAST_ROW_BASE = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] LAST_ADDR     = AW'(ROWS * COLS - 1);
  localparam logic [CW-1:0] LAST_COL      = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW      = RW'(ROWS - 1);
  localparam logic [15:0]   BLANK         = 16'h0020;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd1;
  localparam logic [2:0] S_SCROLL_RD = 3'd2;
  localparam logic [2:0] S_SCROLL_WR = 3'd3;
  localparam logic [2:0] S_CLEAR_ROW = 3'd4;
  localparam logic [2:0] S_CLEAR_ALL = 3'd5;

  logic [2:0]    state_q,    state_d;
  logic [7:0]    code_q,     code_d;
  logic [CW-1:0] col_q,      col_d;
  logic [RW-1:0] row_q,      row_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] idx_q,      idx_d;
  logic [AW-1:0] fb_addr_q,  fb_addr_d;
  logic [15:0]   fb_din_q,   fb_din_d;
  logic          fb_we_q,    fb_we_d;
  logic          ready_q,    ready_d;
  logic          busy_q,     busy_d;

  logic [AW-1:0] cur_addr;
  logic          in_print;
  logic          q_print;
  logic          newline;

  assign cur_addr = row_base_q + AW'(col_q);
  assign in_print = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign q_print  = (code_q >= 8'h20) && (code_q <= 8'h7E);

  // Next-state and next-output logic; outputs are registered from the _d values.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    idx_d      = idx_q;
    fb_addr_d  = fb_addr_q;
    fb_din_d   = fb_din_q;
    fb_we_d    = 1'b0;
    newline    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (char_valid) begin
          code_d = char_data;
          if (char_data == 8'h0C) begin
            // Clear starts writing right away so it costs exactly ROWS*COLS cycles.
            state_d   = S_CLEAR_ALL;
            idx_d     = '0;
            fb_addr_d = '0;
            fb_din_d  = BLANK;
            fb_we_d   = 1'b1;
          end else begin
            state_d = S_WRITE;
            if (in_print) begin
              fb_addr_d = cur_addr;
              fb_din_d  = {char_color, char_data[6:0]};
              fb_we_d   = 1'b1;
            end
          end
        end
      end

      // Write/decode cycle: the cursor moves at the end of it.
      S_WRITE: begin
        state_d = S_IDLE;
        if (q_print) begin
          if (col_q == LAST_COL) begin
            col_d   = '0;
            newline = 1'b1;
          end else begin
            col_d = col_q + CW'(1);
          end
        end else if (code_q == 8'h0D) begin
          col_d = '0;
        end else if (code_q == 8'h0A) begin
          newline = 1'b1;
        end

        if (newline) begin
          if (row_q != LAST_ROW) begin
            row_d      = row_q + RW'(1);
            row_base_d = row_base_q + COLS_A;
          end else begin
            state_d   = S_SCROLL_RD;
            idx_d     = '0;
            fb_addr_d = COLS_A;
          end
        end
      end

      S_SCROLL_RD: begin
        state_d   = S_SCROLL_WR;
        fb_addr_d = idx_q;
        fb_we_d   = 1'b1;
      end

      S_SCROLL_WR: begin
        if (idx_q == SCROLL_LAST) begin
          state_d   = S_CLEAR_ROW;
          idx_d     = LAST_ROW_BASE;
          fb_addr_d = LAST_ROW_BASE;
          fb_din_d  = BLANK;
          fb_we_d   = 1'b1;
        end else begin
          state_d   = S_SCROLL_RD;
          idx_d     = idx_q + AW'(1);
          fb_addr_d = idx_q + AW'(1) + COLS_A;
        end
      end

      S_CLEAR_ROW, S_CLEAR_ALL: begin
        if (idx_q == LAST_ADDR) begin
          state_d = S_IDLE;
          if (state_q == S_CLEAR_ALL) begin
            col_d      = '0;
            row_d      = '0;
            row_base_d = '0;
          end
        end else begin
          idx_d     = idx_q + AW'(1);
          fb_addr_d = idx_q + AW'(1);
          fb_din_d  = BLANK;
          fb_we_d   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge axi4clk) begin
    if (reset_axi) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      idx_q      <= '0;
      fb_addr_q  <= '0;
      fb_din_q   <= '0;
      fb_we_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      idx_q      <= idx_d;
      fb_addr_q  <= fb_addr_d;
      fb_din_q   <= fb_din_d;
      fb_we_q    <= fb_we_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // During a copy write the read word only arrives in that same cycle, so it
  // is forwarded straight to the write port instead of through fb_din_q.
  assign fb_din     = (state_q == S_SCROLL_WR) ? fb_dout : fb_din_q;
  assign fb_addr    = fb_addr_q;
  assign fb_we      = fb_we_q;
  assign char_ready = ready_q;
  assign busy       = busy_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_char_console_ctrl.sv
// Bench for char_console_ctrl on a 4x3 console with a 1-cycle-latency
// frame-buffer model. A reference model holds the expected screen contents,
// cursor, busy time and write count per accepted byte.
module tb_char_console_ctrl;

  localparam int unsigned COLS = 4;
  localparam int unsigned ROWS = 3;
  localparam int unsigned AW   = 4;
  localparam int          NW   = COLS * ROWS;

  logic          axi4clk    = 1'b0;
  logic          reset_axi  = 1'b1;
  logic          char_valid = 1'b0;
  logic          char_ready;
  logic [7:0]    char_data  = 8'h00;
  logic [8:0]    char_color = 9'h000;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_din;
  logic          fb_we;
  logic [15:0]   fb_dout    = 16'h0000;
  logic [1:0]    cursor_col;
  logic [1:0]    cursor_row;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] fbm     [16];
  logic [15:0] ref_mem [NW];
  logic        preload_req = 1'b1;
  int          m_col = 0;
  int          m_row = 0;

  logic          first_we;
  logic [AW-1:0] first_addr;
  logic [15:0]   first_din;
  int            last_nb;

  char_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
    .axi4clk    (axi4clk),
    .reset_axi  (reset_axi),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_data  (char_data),
    .char_color (char_color),
    .fb_addr    (fb_addr),
    .fb_din     (fb_din),
    .fb_we      (fb_we),
    .fb_dout    (fb_dout),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 axi4clk = ~axi4clk;

  // Frame buffer: synchronous read-first RAM, optionally reloaded with addr*3.
  always @(posedge axi4clk) begin
    if (preload_req) begin
      for (int a = 0; a < 16; a++) fbm[a] <= 16'(a * 3);
    end else if (fb_we) begin
      fbm[fb_addr] <= fb_din;
    end
    fb_dout <= fbm[fb_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Screen-level model: applies one byte, returns expected busy cycles and writes.
  task automatic model_apply(input logic [7:0] ch, input logic [8:0] c,
                             output int ebusy, output int ewr);
    bit nl;
    nl    = 1'b0;
    ebusy = 1;
    ewr   = 0;
    if (ch == 8'h0C) begin
      for (int a = 0; a < NW; a++) ref_mem[a] = 16'h0020;
      m_col = 0;
      m_row = 0;
      ebusy = NW;
      ewr   = NW;
      return;
    end
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      ref_mem[m_row * COLS + m_col] = {c, ch[6:0]};
      ewr = 1;
      if (m_col == COLS - 1) begin
        m_col = 0;
        nl    = 1'b1;
      end else begin
        m_col++;
      end
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h0A) begin
      nl = 1'b1;
    end
    if (nl) begin
      if (m_row < ROWS - 1) begin
        m_row++;
      end else begin
        for (int a = 0; a < (ROWS - 1) * COLS; a++) ref_mem[a] = ref_mem[a + COLS];
        for (int a = (ROWS - 1) * COLS; a < NW; a++) ref_mem[a] = 16'h0020;
        ebusy += 2 * (ROWS - 1) * COLS + COLS;
        ewr   += (ROWS - 1) * COLS + COLS;
      end
    end
  endtask

  // Reload RAM and model with addr*3 while the block is idle.
  task automatic preload();
    for (int a = 0; a < NW; a++) ref_mem[a] = 16'(a * 3);
    preload_req = 1'b1;
    @(posedge axi4clk);
    #1 preload_req = 1'b0;
    @(negedge axi4clk);
  endtask

  // Called at a negedge: hand over one byte, follow the busy period, compare.
  task automatic send(input logic [7:0] ch, input logic [8:0] c);
    int eb, ew, nb, nw, t, diff;
    t = 0;
    while (!char_ready && t < 200) begin
      @(negedge axi4clk);
      t++;
    end
    chk("ready_wait", 32'(t < 200), 32'd1);
    char_valid = 1'b1;
    char_data  = ch;
    char_color = c;
    @(posedge axi4clk);
    #1;
    char_valid = 1'b0;
    char_data  = 8'($urandom);
    char_color = 9'($urandom);
    model_apply(ch, c, eb, ew);
    nb = 0;
    nw = 0;
    @(negedge axi4clk);
    first_we   = fb_we;
    first_addr = fb_addr;
    first_din  = fb_din;
    while (busy && nb < 200) begin
      nb++;
      if (fb_we) nw++;
      @(negedge axi4clk);
    end
    last_nb = nb;
    chk("busy_cycles", 32'(nb), 32'(eb));
    chk("write_count", 32'(nw), 32'(ew));
    chk("cursor_col", 32'(cursor_col), 32'(m_col));
    chk("cursor_row", 32'(cursor_row), 32'(m_row));
    chk("ready_after", 32'(char_ready), 32'd1);
    chk("we_idle", 32'(fb_we), 32'd0);
    diff = 0;
    for (int a = 0; a < NW; a++) if (fbm[a] !== ref_mem[a]) diff++;
    chk("mem_diff", 32'(diff), 32'd0);
  endtask

  initial begin
    int r;
    logic [7:0] ch;
    for (int a = 0; a < NW; a++) ref_mem[a] = 16'(a * 3);

    repeat (3) @(posedge axi4clk);
    @(negedge axi4clk);
    chk("rst_ready", 32'(char_ready), 32'd1);
    chk("rst_we", 32'(fb_we), 32'd0);
    chk("rst_addr", 32'(fb_addr), 32'd0);
    chk("rst_din", 32'(fb_din), 32'd0);
    chk("rst_col", 32'(cursor_col), 32'd0);
    chk("rst_row", 32'(cursor_row), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_axi   = 1'b0;
    preload_req = 1'b0;
    @(negedge axi4clk);

    // First printable character
    send(8'h41, 9'h1C0);
    chk("a_we", 32'(first_we), 32'd1);
    chk("a_addr", 32'(first_addr), 32'd0);
    chk("a_din", 32'(first_din), 32'hE041);
    chk("a_busy", 32'(last_nb), 32'd1);

    // Clear screen
    send(8'h0C, 9'h000);
    chk("ff_busy", 32'(last_nb), 32'd12);
    chk("ff_first_addr", 32'(first_addr), 32'd0);

    // Wrap at end of row, then CR/LF
    send(8'h41, 9'h001);
    send(8'h42, 9'h002);
    send(8'h43, 9'h004);
    send(8'h44, 9'h008);
    chk("wrap_col", 32'(cursor_col), 32'd0);
    chk("wrap_row", 32'(cursor_row), 32'd1);
    send(8'h0D, 9'h000);
    send(8'h0A, 9'h000);
    chk("crlf_row", 32'(cursor_row), 32'd2);

    // Move to last cell, reload RAM, then write there to force a scroll
    send(8'h78, 9'h010);
    send(8'h79, 9'h020);
    send(8'h7A, 9'h040);
    preload();
    send(8'h5A, 9'h000);
    chk("z_addr", 32'(first_addr), 32'd11);
    chk("z_din", 32'(first_din), 32'h005A);
    chk("z_busy", 32'(last_nb), 32'd21);

    // Ignored codes
    send(8'h07, 9'h1FF);
    send(8'h7F, 9'h1FF);

    // Random byte stream
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 15));
      if (r <= 8)       ch = 8'($urandom_range(32, 126));
      else if (r == 9)  ch = 8'h0D;
      else if (r <= 11) ch = 8'h0A;
      else if (r == 12) ch = 8'h0C;
      else              ch = 8'($urandom_range(0, 255));
      send(ch, 9'($urandom));
    end

    // Reset in the middle of a scroll
    send(8'h0C, 9'h000);
    send(8'h0A, 9'h000);
    send(8'h0A, 9'h000);
    char_valid = 1'b1;
    char_data  = 8'h0A;
    @(posedge axi4clk);
    #1 char_valid = 1'b0;
    repeat (8) @(negedge axi4clk);
    chk("mid_scroll_busy", 32'(busy), 32'd1);
    reset_axi = 1'b1;
    @(negedge axi4clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_we", 32'(fb_we), 32'd0);
    chk("abort_ready", 32'(char_ready), 32'd1);
    chk("abort_col", 32'(cursor_col), 32'd0);
    chk("abort_row", 32'(cursor_row), 32'd0);
    reset_axi = 1'b0;
    m_col = 0;
    m_row = 0;
    @(negedge axi4clk);
    send(8'h0C, 9'h000);
    send(8'h48, 9'h0AA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
